// File: rtl/mult_pkg.sv
// Shared types and constants for the pipelined multiplier stream.
package mult_pkg;

    localparam int unsigned PERF_CNT_WIDTH = 32;
    localparam int unsigned MAX_STAGES     = 8;

    typedef enum logic {
        MULT_UNSIGNED = 1'b0,
        MULT_SIGNED   = 1'b1
    } mult_mode_e;

endpackage : mult_pkg

// File: rtl/mult_pipe_stage.sv
// One elastic register stage: valid bit plus data and tag payload.
// The stage loads its upstream neighbour whenever advance_i is high.
// Payload is only overwritten by valid data, so a drained stage keeps its last value.
module mult_pipe_stage #(
    parameter int unsigned DATA_WIDTH = 54,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  advance_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [TAG_WIDTH-1:0]  tag_q,   tag_d;

    // Next-state: hold unless advancing; take payload only from a valid upstream entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (advance_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
                tag_d  = tag_i;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

endmodule : mult_pipe_stage

// File: rtl/pipelined_multiplier_stream.sv
// Elastic WIDTH x WIDTH multiplier with STAGES register stages, valid/ready on
// both sides, per-transaction signed/unsigned mode and a sideband tag.
// Optional build macro PIPELINED_MULT_PERF_EN adds perf_accepted / perf_stall counters.
module pipelined_multiplier_stream
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 27,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [WIDTH-1:0]       in1,
    input  logic [WIDTH-1:0]       in2,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out,
    output logic [TAG_WIDTH-1:0]   out_tag
`ifdef PIPELINED_MULT_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_accepted,
    output logic [PERF_CNT_WIDTH-1:0] perf_stall
`endif
);

    localparam int unsigned PW = 2 * WIDTH;

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipelined_multiplier_stream: STAGES out of range");
    end

    mult_mode_e           mode;
    logic                 sign_ext;
    logic [PW-1:0]        op1_ext, op2_ext, product;

    logic [STAGES-1:0]    st_valid;
    logic [PW-1:0]        st_data [STAGES];
    logic [TAG_WIDTH-1:0] st_tag  [STAGES];

    logic [STAGES-1:0]    stg_in_valid;
    logic [PW-1:0]        stg_in_data [STAGES];
    logic [TAG_WIDTH-1:0] stg_in_tag  [STAGES];

    logic [STAGES-1:0]    advance;

    // Extend both operands to 2*WIDTH per the mode; the low 2*WIDTH bits of the
    // product are then exact for both signed and unsigned operands.
    always_comb begin
        mode     = mult_mode_e'(in_signed);
        sign_ext = (mode == MULT_SIGNED);
        op1_ext  = {{WIDTH{sign_ext & in1[WIDTH-1]}}, in1};
        op2_ext  = {{WIDTH{sign_ext & in2[WIDTH-1]}}, in2};
        product  = op1_ext * op2_ext;
    end

    // A stage advances when the consumer is ready or any stage at or downstream
    // of it is empty; flattening the recursive form keeps this loop-free.
    always_comb begin
        advance = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            advance[s] = out_ready;
            for (int unsigned j = s; j < STAGES; j++) begin
                advance[s] = advance[s] | ~st_valid[j];
            end
        end
    end

    // Stage 0 takes the fresh product; later stages take their upstream neighbour.
    always_comb begin
        stg_in_valid    = '0;
        stg_in_valid[0] = in_valid;
        stg_in_data[0]  = product;
        stg_in_tag[0]   = in_tag;
        for (int unsigned s = 1; s < STAGES; s++) begin
            stg_in_valid[s] = st_valid[s-1];
            stg_in_data[s]  = st_data[s-1];
            stg_in_tag[s]   = st_tag[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        mult_pipe_stage #(
            .DATA_WIDTH (PW),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_stage (
            .clk_i     (clk),
            .rst_i     (rst),
            .advance_i (advance[s]),
            .valid_i   (stg_in_valid[s]),
            .data_i    (stg_in_data[s]),
            .tag_i     (stg_in_tag[s]),
            .valid_o   (st_valid[s]),
            .data_o    (st_data[s]),
            .tag_o     (st_tag[s])
        );
    end

    assign in_ready  = ~rst & advance[0];
    assign out_valid = st_valid[STAGES-1];
    assign out       = st_data[STAGES-1];
    assign out_tag   = st_tag[STAGES-1];

`ifdef PIPELINED_MULT_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_accepted_q, perf_accepted_d;
    logic [PERF_CNT_WIDTH-1:0] perf_stall_q,    perf_stall_d;

    // Saturating counters of input transfers and output stall cycles.
    always_comb begin
        perf_accepted_d = perf_accepted_q;
        perf_stall_d    = perf_stall_q;
        if (in_valid && in_ready && perf_accepted_q != '1) begin
            perf_accepted_d = perf_accepted_q + 1'b1;
        end
        if (out_valid && !out_ready && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_accepted_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_accepted_q <= perf_accepted_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_accepted = perf_accepted_q;
    assign perf_stall    = perf_stall_q;
`endif

endmodule : pipelined_multiplier_stream

// File: tb/tb_pipelined_multiplier_stream.sv
// Self-checking bench for pipelined_multiplier_stream (WIDTH=27, STAGES=2, TAG_WIDTH=4).
module tb_pipelined_multiplier_stream;

    localparam int W  = 27;
    localparam int ST = 2;
    localparam int TW = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out;
    logic [TW-1:0] out_tag;
`ifdef PIPELINED_MULT_PERF_EN
    logic [31:0]   perf_accepted;
    logic [31:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    pipelined_multiplier_stream #(
        .WIDTH     (W),
        .STAGES    (ST),
        .TAG_WIDTH (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in1       (in1),
        .in2       (in2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag)
`ifdef PIPELINED_MULT_PERF_EN
        ,
        .perf_accepted (perf_accepted),
        .perf_stall    (perf_stall)
`endif
    );

    typedef struct {
        logic [PW-1:0] prod;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int unsigned m_acc = 0;
    int unsigned m_stall = 0;
    logic        rst_prev = 1'b1;
    logic        prev_stall = 1'b0;
    logic [PW-1:0] prev_out = '0;
    logic [TW-1:0] prev_tag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference product by plain integer arithmetic on the operand values.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint ia, ib, p;
        ia = longint'(a);
        ib = longint'(b);
        if (s && a[W-1]) ia = ia - (longint'(1) <<< W);
        if (s && b[W-1]) ib = ib - (longint'(1) <<< W);
        p = ia * ib;
        return p[PW-1:0];
    endfunction

    // Compare process: transaction queue model; an entry reaches the output
    // ST cycles after acceptance, occupancy gates in_ready under backpressure.
    always @(negedge clk) begin : compare
        logic ev;
        exp_t e;
        ev = (q.size() > 0) && ((cyc - q[0].acc) >= ST);
        chk("in_ready", in_ready, rst ? 1'b0 : ((q.size() < ST) || out_ready));
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("out_data", out, q[0].prod);
            chk("out_tag", out_tag, q[0].tag);
        end
        if (rst_prev) begin
            chk("rst_out", out, 0);
            chk("rst_tag", out_tag, 0);
        end
        if (prev_stall && !rst_prev) begin
            chk("stall_out_stable", out, prev_out);
            chk("stall_tag_stable", out_tag, prev_tag);
        end
`ifdef PIPELINED_MULT_PERF_EN
        chk("perf_accepted", perf_accepted, m_acc);
        chk("perf_stall", perf_stall, m_stall);
`endif
        if (rst) begin
            q.delete();
            m_acc   = 0;
            m_stall = 0;
        end else begin
            if (ev && !out_ready) m_stall++;
            if (ev && out_ready) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                e.prod = ref_mul(in1, in2, in_signed);
                e.tag  = in_tag;
                e.acc  = cyc;
                q.push_back(e);
                m_acc++;
            end
        end
        prev_stall = !rst && ev && !out_ready;
        prev_out   = out;
        prev_tag   = out_tag;
        rst_prev   = rst;
        cyc++;
    end

    task automatic latency_test(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic [TW-1:0] t, input logic [PW-1:0] want);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in1 = a; in2 = b; in_signed = s; in_tag = t; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, lat, ST);
        chk({nm, "_product"}, out, want);
        chk({nm, "_tag"}, out_tag, t);
        @(negedge clk);
        chk({nm, "_one_cycle"}, out_valid, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int next, out_before;
        logic saw_full;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1'b1);

        // Directed latency and arithmetic corners.
        latency_test("umax",   27'h7FFFFFF, 27'h7FFFFFF, 1'b0, 4'd5,  54'h3FFFFFF0000001);
        latency_test("s_m1x3", 27'h7FFFFFF, 27'd3,       1'b1, 4'd6,  54'h3FFFFFFFFFFFFD);
        latency_test("s_min2", 27'h4000000, 27'h4000000, 1'b1, 4'd7,  54'h10000000000000);
        latency_test("u_m1x3", 27'h7FFFFFF, 27'd3,       1'b0, 4'd8,  54'h00000017FFFFFD);
        latency_test("u_min2", 27'h4000000, 27'h4000000, 1'b0, 4'd9,  54'h10000000000000);
        latency_test("s_m1m1", 27'h7FFFFFF, 27'h7FFFFFF, 1'b1, 4'd10, 54'h00000000000001);

        // Backpressure: 10 back-to-back inputs, consumer stalled for cycles 3..8.
        next = 0;
        saw_full = 1'b0;
        out_before = n_out;
        for (int c = 0; c < 60 && (next < 10 || q.size() > 0); c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c <= 8);
            if (next < 10) begin
                in_valid  = 1'b1;
                in1       = W'(next * 12345 + 7);
                in2       = W'(27'h7FFFFFF - next * 999);
                in_signed = next[0];
                in_tag    = TW'(next);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) next++;
            if (!in_ready) saw_full = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", next, 10);
        chk("bp_in_ready_fell", saw_full, 1'b1);
        chk("bp_all_delivered", n_out - out_before, 10);

        // Random traffic with a drain at the end.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_signed = 1'($urandom_range(0, 1));
            in1       = W'($urandom);
            in2       = W'($urandom);
            in_tag    = TW'($urandom);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 3) @(negedge clk);
        chk("random_drained", q.size(), 0);

        // Mid-operation reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in1 = W'(i + 100); in2 = W'(i + 3); in_signed = 1'b0; in_tag = TW'(i + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
`ifdef PIPELINED_MULT_PERF_EN
        chk("perf_accepted_cleared", perf_accepted, 0);
        chk("perf_stall_cleared", perf_stall, 0);
`endif
        for (int k = 0; k < 6; k++) begin
            chk("no_valid_after_rst", out_valid, 1'b0);
            @(negedge clk);
        end

        // Pipeline still works after the reset.
        latency_test("post_rst", 27'd1000, 27'd2000, 1'b0, 4'd3, 54'd2000000);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipelined_multiplier_stream
